// File: rtl/dcache_core_data_seq_pkg.sv
// dcache_core_data_seq_pkg: shared dcache data-sequencer state encodings and line geometry defaults
package dcache_core_data_seq_pkg;
  localparam int LINE_WORDS_DEF = 8;
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVICT, S_DONE} state_e;
endpackage

// File: rtl/dcache_core_data_seq_fifo.sv
// dcache_core_data_seq_fifo: 2-entry evict word buffer; caller guarantees no overflow or underflow
module dcache_core_data_seq_fifo #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   cnt_o
);
  logic [1:0][W-1:0] mem_q;
  logic              wp_q, rp_q;
  logic [1:0]        cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) mem_q[wp_q] <= data_i;
      wp_q  <= wp_q ^ push_i;
      rp_q  <= rp_q ^ pop_i;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
  assign data_o = mem_q[rp_q];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/dcache_core_data_seq.sv
// dcache_core_data_seq: streams one cache line between the data RAM and the fill/evict ports
module dcache_core_data_seq
  import dcache_core_data_seq_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int LINE_W     = 8,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int CNT_W     = OFF_W + 1,
  localparam int AW        = LINE_W + OFF_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic              cmd_evict_i,
  input  logic [LINE_W-1:0] cmd_line_i,
  output logic              cmd_accept_o,
  input  logic              fill_valid_i,
  input  logic [31:0]       fill_data_i,
  output logic              fill_accept_o,
  output logic              evict_valid_o,
  output logic [31:0]       evict_data_o,
  output logic              evict_last_o,
  input  logic              evict_accept_i,
  output logic              done_o,
  output logic              busy_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_wr_o,
  input  logic [31:0]       ram_data_i
);
  state_e            state_q, state_d;
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  wcnt_q, rcnt_q;
  logic              pend_q;
  logic [1:0]        fcnt;
  logic [31:0]       fhead;
  logic              start, fill_we, pop, rd_issue, last_word;
  assign start     = state_q == S_IDLE && cmd_valid_i;
  assign last_word = wcnt_q == CNT_W'(LINE_WORDS - 1);
  assign fill_we   = state_q == S_FILL && fill_valid_i && !rst_i;
  assign pop       = evict_valid_o && evict_accept_i;
  // a word leaving this cycle frees its slot, which keeps the stream at one word per cycle
  assign rd_issue  = state_q == S_EVICT && rcnt_q != CNT_W'(LINE_WORDS) &&
                     ({1'b0, fcnt} + {2'b0, pend_q} - {2'b0, pop}) < 3'd2;
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = start ? (cmd_evict_i ? S_EVICT : S_FILL) :
              (state_q == S_FILL && fill_valid_i && last_word) ||
              (state_q == S_EVICT && pop && last_word) ? S_DONE :
              state_q == S_DONE ? S_IDLE : state_q;
  end
  always_comb begin
    cmd_accept_o  = state_q == S_IDLE;
    fill_accept_o = state_q == S_FILL;
    busy_o        = state_q != S_IDLE;
    done_o        = state_q == S_DONE;
    evict_valid_o = state_q == S_EVICT && fcnt != 2'd0;
    evict_data_o  = evict_valid_o ? fhead : 32'h0;
    evict_last_o  = evict_valid_o && last_word;
    ram_wr_o      = fill_we ? 4'hF : 4'h0;
    ram_data_o    = fill_we ? fill_data_i : 32'h0;
    ram_addr_o    = state_q == S_FILL  ? {line_q, wcnt_q[OFF_W-1:0]} :
                    state_q == S_EVICT ? {line_q, rcnt_q[OFF_W-1:0]} : '0;
  end
  // wcnt counts written words in FILL and consumed words in EVICT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= '0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= rd_issue;
      if (start) begin
        line_q <= cmd_line_i;
        wcnt_q <= '0;
        rcnt_q <= '0;
      end else begin
        if (fill_we || pop) wcnt_q <= wcnt_q + CNT_W'(1);
        if (rd_issue) rcnt_q <= rcnt_q + CNT_W'(1);
      end
    end
  end
  dcache_core_data_seq_fifo #(.W(32)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (pend_q),
    .data_i (ram_data_i),
    .pop_i  (pop),
    .data_o (fhead),
    .cnt_o  (fcnt)
  );
endmodule

// File: tb/tb_dcache_core_data_seq.sv
// tb_dcache_core_data_seq: directed table and sequence checks of the line fill/evict sequencer
module tb_dcache_core_data_seq;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        cmd_valid_i = 0, cmd_evict_i = 0, fill_valid_i = 0, evict_accept_i = 0;
  logic [7:0]  cmd_line_i = 0;
  logic [31:0] fill_data_i = 0, ram_data_i = 0;
  logic        cmd_accept_o, fill_accept_o, evict_valid_o, evict_last_o, done_o, busy_o;
  logic [31:0] evict_data_o, ram_data_o;
  logic [10:0] ram_addr_o;
  logic [3:0]  ram_wr_o;
  logic [31:0] mem [0:2047];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dcache_core_data_seq dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_evict_i(cmd_evict_i),
    .cmd_line_i(cmd_line_i), .cmd_accept_o(cmd_accept_o), .fill_valid_i(fill_valid_i),
    .fill_data_i(fill_data_i), .fill_accept_o(fill_accept_o), .evict_valid_o(evict_valid_o),
    .evict_data_o(evict_data_o), .evict_last_o(evict_last_o), .evict_accept_i(evict_accept_i),
    .done_o(done_o), .busy_o(busy_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_wr_o(ram_wr_o), .ram_data_i(ram_data_i)
  );
  always @(posedge clk) begin
    if (ram_wr_o == 4'hF) mem[ram_addr_o] <= ram_data_o;
    ram_data_i <= mem[ram_addr_o];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic cv, ce; logic [7:0] ln; logic fv; logic [31:0] fd;
    logic ca, fa, bz, dn; logic [3:0] wr; logic [10:0] ad;
  } vec_t;
  vec_t tbl [12];
  task automatic fill(input logic [7:0] ln, input logic [31:0] base, input int gap);
    int w = 0;
    bit dn = 0;
    @(negedge clk); cmd_valid_i = 1; cmd_evict_i = 0; cmd_line_i = ln;
    @(negedge clk); cmd_valid_i = 0;
    for (int c = 0; c < 100 && !dn; c++) begin
      fill_valid_i = (c % gap == 0) && w < 8;
      fill_data_i = base + w;
      #1;
      if (done_o) begin
        dn = 1;
        chk("fill_done_count", w, 8);
        chk("fill_done_wr", ram_wr_o, 4'h0);
      end else if (fill_valid_i) begin
        chk("fill_wr", ram_wr_o, 4'hF);
        chk("fill_addr", ram_addr_o, {ln, w[2:0]});
        chk("fill_data", ram_data_o, base + w);
        w++;
      end else chk("fill_idle_wr", ram_wr_o, 4'h0);
      if (!dn) @(negedge clk);
    end
    fill_valid_i = 0;
    chk("fill_timeout", dn, 1);
    for (int i = 0; i < 8; i++) chk("fill_mem", mem[{ln, 3'(i)}], base + i);
  endtask
  task automatic evict(input logic [7:0] ln, input logic [31:0] base, input bit rnd, input int stop_at);
    int k = 0, first = -1, lastc = -1, ahead;
    bit dn = 0;
    @(negedge clk); cmd_valid_i = 1; cmd_evict_i = 1; cmd_line_i = ln; evict_accept_i = 0;
    #1 chk("ev_cmd_accept", cmd_accept_o, 1);
    @(negedge clk); cmd_valid_i = 0;
    for (int c = 0; c < 200 && !dn; c++) begin
      evict_accept_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (done_o) begin
        dn = 1;
        chk("ev_done_valid", evict_valid_o, 0);
        chk("ev_done_count", k, 8);
        chk("ev_done_timing", c, lastc + 1);
      end else begin
        ahead = (ram_addr_o[2:0] == 3'd0 && k > 0) ? 8 - k : int'(ram_addr_o[2:0]) - k;
        chk("ev_reads_ahead", ahead >= 0 && ahead <= 2, 1);
        chk("ev_fill_accept", fill_accept_o, 0);
        if (evict_valid_o && evict_accept_i) begin
          chk("ev_data", evict_data_o, base + k);
          chk("ev_last", evict_last_o, k == 7);
          if (first < 0) first = c;
          lastc = c;
          k++;
          if (k == stop_at) return;
        end
      end
      if (!dn) @(negedge clk);
    end
    evict_accept_i = 0;
    chk("ev_timeout", dn, 1);
    if (!rnd) chk("ev_back_to_back", lastc - first, 7);
  endtask
  initial begin
    bit dn;
    foreach (mem[i]) mem[i] = 32'h0;
    tbl[0]  = '{0, 0, 8'h00, 0, 32'h0, 1, 0, 0, 0, 4'h0, 11'h000};
    tbl[1]  = '{1, 0, 8'h05, 0, 32'h0, 1, 0, 0, 0, 4'h0, 11'h000};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{0, 0, 8'h00, 1, 32'h1000_0000 + i, 0, 1, 1, 0, 4'hF, 11'h028 + 11'(i)};
    tbl[10] = '{0, 0, 8'h00, 0, 32'h0, 0, 0, 1, 1, 4'h0, 11'h000};
    tbl[11] = '{0, 0, 8'h00, 0, 32'h0, 1, 0, 0, 0, 4'h0, 11'h000};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_accept", cmd_accept_o, 1);
    chk("rst_fill_accept", fill_accept_o, 0);
    chk("rst_evict_valid", evict_valid_o, 0);
    chk("rst_evict_data", evict_data_o, 0);
    chk("rst_evict_last", evict_last_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    chk("rst_ram_data", ram_data_o, 0);
    chk("rst_ram_wr", ram_wr_o, 0);
    rst_i = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cmd_valid_i = tbl[i].cv; cmd_evict_i = tbl[i].ce; cmd_line_i = tbl[i].ln;
      fill_valid_i = tbl[i].fv; fill_data_i = tbl[i].fd;
      #1;
      chk("tbl_cmd_accept", cmd_accept_o, tbl[i].ca);
      chk("tbl_fill_accept", fill_accept_o, tbl[i].fa);
      chk("tbl_busy", busy_o, tbl[i].bz);
      chk("tbl_done", done_o, tbl[i].dn);
      chk("tbl_ram_wr", ram_wr_o, tbl[i].wr);
      if (tbl[i].wr == 4'hF) begin
        chk("tbl_ram_addr", ram_addr_o, tbl[i].ad);
        chk("tbl_ram_data", ram_data_o, tbl[i].fd);
      end
    end
    for (int i = 0; i < 8; i++) chk("tbl_mem", mem[11'h028 + 11'(i)], 32'h1000_0000 + i);
    evict(8'h05, 32'h1000_0000, 0, 0);
    evict(8'h05, 32'h1000_0000, 1, 0);
    fill(8'h0A, 32'hA000_0000, 3);
    evict(8'h0A, 32'hA000_0000, 0, 3);
    @(negedge clk); rst_i = 1; evict_accept_i = 0;
    #1 chk("rst_ev_wr", ram_wr_o, 4'h0);
    @(negedge clk); rst_i = 0;
    #1;
    chk("rst_ev_busy", busy_o, 0);
    chk("rst_ev_valid", evict_valid_o, 0);
    chk("rst_ev_cmd_accept", cmd_accept_o, 1);
    fill(8'hFF, 32'hF000_0000, 1);
    @(negedge clk); cmd_valid_i = 1; cmd_evict_i = 0; cmd_line_i = 8'h20;
    @(negedge clk); cmd_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      fill_valid_i = 1; fill_data_i = 32'h2000_0000 + i;
      @(negedge clk);
    end
    rst_i = 1; fill_data_i = 32'hDEAD_BEEF;
    #1 chk("rst_fill_no_wr", ram_wr_o, 4'h0);
    @(negedge clk); rst_i = 0; fill_valid_i = 0;
    #1;
    for (int i = 0; i < 3; i++) chk("rst_fill_kept", mem[11'h100 + 11'(i)], 32'h2000_0000 + i);
    chk("rst_fill_untouched", mem[11'h103], 32'h0);
    chk("rst_fill_idle", busy_o, 0);
    @(negedge clk); cmd_valid_i = 1; cmd_evict_i = 1; cmd_line_i = 8'h05; evict_accept_i = 1;
    dn = 0;
    for (int c = 0; c < 100 && !dn; c++) begin
      #1;
      if (done_o) dn = 1;
      else @(negedge clk);
    end
    chk("hold_done_seen", dn, 1);
    chk("hold_accept_in_done", cmd_accept_o, 0);
    @(negedge clk); #1;
    chk("hold_accept_after_done", cmd_accept_o, 1);
    chk("hold_idle_after_done", busy_o, 0);
    @(negedge clk); cmd_valid_i = 0;
    #1 chk("hold_second_taken", busy_o, 1);
    dn = 0;
    for (int c = 0; c < 100 && !dn; c++) begin
      #1;
      if (done_o) dn = 1;
      else @(negedge clk);
    end
    chk("hold_second_done", dn, 1);
    evict_accept_i = 0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
